// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- shares one UART TX FIFO write port among NREQ byte sources.
//
// Each requester owns a one-byte holding slot. Full slots are issued to the
// FIFO round-robin, at most one byte every other cycle so that a FIFO-full
// indication caused by the previous write is always observed before the next
// one. A byte issued with last=0 locks the port to its requester until that
// requester issues a byte with last=1, or until the owner leaves its slot
// empty for LOCK_TIMEOUT cycles, at which point the lock is forcibly dropped.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   req_valid_i    per-requester byte valid
//   req_data_i     per-requester byte, requester i at [i*DBIT +: DBIT]
//   req_last_i     byte ends its message (0 requests / keeps the lock)
//   req_ready_o    holding slot i is empty
//   tx_full_i      UART TX FIFO full
//   wr_uart_o      FIFO write strobe (registered, single-cycle)
//   wr_data_o      FIFO write data (registered)
//   locked_o       arbiter is in the LOCKED state
//   owner_o        current / most recently granted requester index
//   timeout_err_o  one-cycle pulse when a lock is forcibly released

// One holding slot: captures a byte on handshake, empties when issued.
module uart_tx_arb_slot #(
  parameter int DBIT = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic [DBIT-1:0] data_i,
  input  logic            last_i,
  input  logic            clr_i,
  output logic            full_o,
  output logic [DBIT-1:0] data_o,
  output logic            last_o
);

  logic            full_q, full_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic            load;

  // Loading is only possible while empty and clearing only while full,
  // so the two never meet on the same edge.
  assign load = valid_i & ~full_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    if (load) begin
      full_d = 1'b1;
      data_d = data_i;
      last_d = last_i;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign last_o = last_q;

endmodule

module uart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int DBIT         = 8,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int TW           = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*DBIT-1:0] req_data_i,
  input  logic [NREQ-1:0]      req_last_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 tx_full_i,
  output logic                 wr_uart_o,
  output logic [DBIT-1:0]      wr_data_o,
  output logic                 locked_o,
  output logic [2:0]           owner_o,
  output logic                 timeout_err_o
);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 rr_q, rr_d;
  logic [2:0]                 owner_q, owner_d;
  logic [TW-1:0]              cnt_q, cnt_d;
  logic                       wr_q, wr_d;
  logic [DBIT-1:0]            wdata_q, wdata_d;
  logic                       terr_q, terr_d;

  logic [NREQ-1:0]            slot_full;
  logic [NREQ-1:0][DBIT-1:0]  slot_data;
  logic [NREQ-1:0]            slot_last;
  logic [NREQ-1:0]            slot_clr;

  logic                       found;
  logic [2:0]                 sel;
  logic [DBIT-1:0]            sel_data;
  logic                       sel_last;
  logic                       own_full;
  logic                       issue;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    uart_tx_arb_slot #(.DBIT(DBIT)) u_slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (req_valid_i[g]),
      .data_i  (req_data_i[g*DBIT +: DBIT]),
      .last_i  (req_last_i[g]),
      .clr_i   (slot_clr[g]),
      .full_o  (slot_full[g]),
      .data_o  (slot_data[g]),
      .last_o  (slot_last[g])
    );
  end

  // Ready comes straight from slot state: no path from tx_full.
  assign req_ready_o = ~slot_full;

  // Owner slot occupancy, found by compare rather than by indexing with the
  // 3-bit owner so that NREQ < 8 needs no out-of-range handling.
  always_comb begin
    own_full = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (owner_q == 3'(i)) own_full = slot_full[i];
  end

  // Eligible slot. IDLE: first full slot at rr+1, rr+2, ... (mod NREQ).
  // LOCKED: only the owner.
  always_comb begin
    found = 1'b0;
    sel   = owner_q;
    if (state_q == S_IDLE) begin
      for (int k = 1; k <= NREQ; k++)
        for (int i = 0; i < NREQ; i++)
          if (!found && slot_full[i] && (i == (int'(rr_q) + k) % NREQ)) begin
            found = 1'b1;
            sel   = 3'(i);
          end
    end else begin
      found = own_full;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (sel == 3'(i)) begin
        sel_data = slot_data[i];
        sel_last = slot_last[i];
      end
  end

  // A write in the current cycle blocks issue, so the FIFO's full flag
  // reflecting that write is seen before the next decision.
  assign issue = found & ~tx_full_i & ~wr_q;

  always_comb begin
    slot_clr = '0;
    for (int i = 0; i < NREQ; i++)
      if (issue && sel == 3'(i)) slot_clr[i] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          wr_d    = 1'b1;
          wdata_d = sel_data;
          owner_d = sel;
          rr_d    = sel;
          if (!sel_last) begin
            state_d = S_LOCKED;
            cnt_d   = '0;
          end
        end
      end
      S_LOCKED: begin
        if (issue) begin
          wr_d    = 1'b1;
          wdata_d = sel_data;
          cnt_d   = '0;
          if (sel_last) state_d = S_IDLE;
        end else if (!own_full) begin
          // Only an empty owner slot ages the lock; a full slot held off by
          // tx_full is waiting on the UART, not on the owner.
          if (cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rr_q    <= 3'(NREQ - 1);
      owner_q <= 3'(NREQ - 1);
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      terr_q  <= terr_d;
    end
  end

  assign wr_uart_o     = wr_q;
  assign wr_data_o     = wdata_q;
  assign locked_o      = (state_q == S_LOCKED);
  assign owner_o       = owner_q;
  assign timeout_err_o = terr_q;

endmodule
